// File: rtl/snn_pkg.sv
// Shared definitions for the SNN image loader: loader FSM states and frame geometry.
package snn_pkg;

   localparam int unsigned NUM_BITS     = 784;
   localparam int unsigned ADDR_W       = 10;
   localparam logic [7:0]  ASCII_OFFSET = 8'h30;

   typedef enum logic [2:0] {
      RX_WAIT,
      WRITE,
      START,
      WAIT_DONE,
      TX
   } loader_state_t;

endpackage

// File: rtl/snn_bit_unpacker.sv
// Holds one received byte and presents it LSB-first, one bit per shift,
// flagging the eighth bit so the loader knows the byte is exhausted.
module snn_bit_unpacker (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_i,
   input  logic [7:0] byte_i,
   input  logic       shift_i,
   output logic       bit_o,
   output logic       last_o
);

   logic [7:0] shift_q, shift_d;
   logic [2:0] cnt_q,   cnt_d;

   // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (load_i) begin
         shift_d = byte_i;
         cnt_d   = '0;
      end else if (shift_i) begin
         shift_d = {1'b0, shift_q[7:1]};
         cnt_d   = cnt_q + 3'd1;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bit_o  = shift_q[0];
   assign last_o = (cnt_q == 3'd7);

endmodule

// File: rtl/snn_image_loader.sv
// Writer side of the SNN input-unit RAM: unpacks UART bytes into one-bit RAM
// writes, starts the core, lends it the RAM address port, and returns the digit.
module snn_image_loader #(
   parameter int unsigned NUM_BITS     = snn_pkg::NUM_BITS,
   parameter logic [7:0]  ASCII_OFFSET = snn_pkg::ASCII_OFFSET
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       rx_rdy,
   input  logic [7:0]                 rx_data,
   output logic                       clr_rx_rdy,
   output logic [snn_pkg::ADDR_W-1:0] ram_addr,
   output logic                       ram_data,
   output logic                       ram_we,
   input  logic [snn_pkg::ADDR_W-1:0] core_addr,
   output logic                       core_start,
   input  logic                       core_done,
   input  logic [3:0]                 core_digit,
   input  logic                       tx_busy,
   output logic                       tx_start,
   output logic [7:0]                 tx_data,
   output logic                       busy
);

   import snn_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BITS - 1);

   loader_state_t     state_q, state_d;
   logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
   logic [3:0]        digit_q, digit_d;

   logic unp_load;
   logic unp_shift;
   logic unp_bit;
   logic unp_last;

   snn_bit_unpacker u_unpacker (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (unp_load),
      .byte_i  (rx_data),
      .shift_i (unp_shift),
      .bit_o   (unp_bit),
      .last_o  (unp_last)
   );

   always_comb begin
      state_d    = state_q;
      addr_cnt_d = addr_cnt_q;
      digit_d    = digit_q;
      unp_load   = 1'b0;
      unp_shift  = 1'b0;
      clr_rx_rdy = 1'b0;
      ram_we     = 1'b0;
      ram_addr   = addr_cnt_q;
      core_start = 1'b0;
      tx_start   = 1'b0;
      tx_data    = '0;

      case (state_q)
         RX_WAIT: begin
            if (rx_rdy) begin
               unp_load   = 1'b1;
               clr_rx_rdy = 1'b1;
               state_d    = WRITE;
            end
         end

         WRITE: begin
            ram_we     = 1'b1;
            unp_shift  = 1'b1;
            addr_cnt_d = addr_cnt_q + ADDR_W'(1);
            // The frame is complete when the eighth bit of a byte lands on the last address.
            if (unp_last) begin
               state_d = (addr_cnt_q == LAST_ADDR) ? START : RX_WAIT;
            end
         end

         START: begin
            core_start = 1'b1;
            addr_cnt_d = '0;
            state_d    = WAIT_DONE;
         end

         WAIT_DONE: begin
            ram_addr = core_addr;
            if (core_done) begin
               digit_d = core_digit;
               state_d = TX;
            end
         end

         TX: begin
            tx_data = ASCII_OFFSET + {4'h0, digit_q};
            if (!tx_busy) begin
               tx_start = 1'b1;
               state_d  = RX_WAIT;
            end
         end

         default: state_d = RX_WAIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RX_WAIT;
         addr_cnt_q <= '0;
         digit_q    <= '0;
      end else begin
         state_q    <= state_d;
         addr_cnt_q <= addr_cnt_d;
         digit_q    <= digit_d;
      end
   end

   assign ram_data = unp_bit;
   assign busy     = (state_q != RX_WAIT);

endmodule

// File: tb/tb_snn_image_loader.sv
// Self-checking bench for snn_image_loader: hand-written byte table, full frames
// against an image model, core hand-off, transmit back-pressure and mid-load reset.
module tb_snn_image_loader;

   localparam int NB    = 98;
   localparam int NBITS = 784;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_rdy = 1'b0;
   logic [7:0] rx_data = '0;
   logic       clr_rx_rdy;
   logic [9:0] ram_addr;
   logic       ram_data;
   logic       ram_we;
   logic [9:0] core_addr = '0;
   logic       core_start;
   logic       core_done = 1'b0;
   logic [3:0] core_digit = '0;
   logic       tx_busy = 1'b0;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       busy;

   always #5 clk = ~clk;

   snn_image_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_rdy     (rx_rdy),
      .rx_data    (rx_data),
      .clr_rx_rdy (clr_rx_rdy),
      .ram_addr   (ram_addr),
      .ram_data   (ram_data),
      .ram_we     (ram_we),
      .core_addr  (core_addr),
      .core_start (core_start),
      .core_done  (core_done),
      .core_digit (core_digit),
      .tx_busy    (tx_busy),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .busy       (busy)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor: RAM image model and event log ----------------
   int   cyc = 0;
   int   wr_addr_q[$];
   int   wr_cyc_q[$];
   logic ram_img[NBITS];
   int   start_cnt = 0;
   int   start_cyc = 0;
   int   tx_cnt = 0;
   int   ack_cyc = 0;

   logic [7:0] frame_bytes[NB];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (ram_we) begin
            wr_addr_q.push_back(int'(ram_addr));
            wr_cyc_q.push_back(cyc);
            if (int'(ram_addr) < NBITS) ram_img[ram_addr] = ram_data;
         end
         if (core_start) begin
            start_cnt++;
            start_cyc = cyc;
         end
         if (tx_start) tx_cnt++;
      end
   end

   task automatic clear_mon();
      wr_addr_q.delete();
      wr_cyc_q.delete();
      foreach (ram_img[i]) ram_img[i] = 1'bx;
      start_cnt = 0;
   endtask

   // ---------------- stimulus helpers (entered and left at posedge+1) ----------------
   task automatic wait_ack();
      bit got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (clr_rx_rdy) begin
            got = 1'b1;
            ack_cyc = cyc;
         end
      end
      check("rx_ack_seen", got, 1);
      @(posedge clk);
      #1 rx_rdy = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_rdy  = 1'b1;
      wait_ack();
   endtask

   task automatic send_frame(input int first, input int max_gap);
      bit got = 1'b0;
      int order_err = 0;
      int img_err = 0;
      if (first == 0) clear_mon();
      for (int k = first; k < NB; k++) begin
         repeat ($urandom_range(max_gap, 0)) begin
            @(posedge clk);
            #1;
         end
         send_byte(frame_bytes[k]);
      end
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         got = (start_cnt != 0);
      end
      check("core_start_seen", got, 1);
      @(posedge clk);
      #1;
      check("write_count", wr_addr_q.size(), NBITS);
      foreach (wr_addr_q[i]) if (wr_addr_q[i] != i) order_err++;
      check("write_order", order_err, 0);
      for (int i = 0; i < NBITS; i++) begin
         logic [7:0] b;
         b = frame_bytes[i / 8];
         if (ram_img[i] !== b[i % 8]) img_err++;
      end
      check("image_bits", img_err, 0);
      check("start_latency_from_ack", start_cyc - ack_cyc, 9);
      if (wr_cyc_q.size() > 0) check("start_after_last_write", start_cyc - wr_cyc_q[$], 1);
      check("start_pulse_count", start_cnt, 1);
      check("busy_wait_done", busy, 1);
   endtask

   task automatic do_result(input logic [3:0] d, input int busy_cyc);
      int early = 0;
      int tx_before;
      tx_before  = tx_cnt;
      tx_busy    = (busy_cyc > 0);
      core_digit = d;
      core_done  = 1'b1;
      @(negedge clk);
      check("tx_idle_during_done", tx_start, 0);
      @(posedge clk);
      #1 core_done = 1'b0;
      core_digit = 4'($urandom);
      for (int i = 0; i < busy_cyc; i++) begin
         @(negedge clk);
         if (tx_start) early++;
         @(posedge clk);
         #1;
      end
      if (busy_cyc > 0) check("tx_held_while_busy", early, 0);
      tx_busy = 1'b0;
      @(negedge clk);
      check("tx_start_pulse", tx_start, 1);
      check("tx_data_ascii", tx_data, 8'h30 + {4'h0, d});
      @(posedge clk);
      #1;
      check("tx_pulse_count", tx_cnt - tx_before, 1);
      check("busy_after_tx", busy, 0);
      check("tx_start_dropped", tx_start, 0);
   endtask

   // ---------------- hand-written byte table ----------------
   typedef struct {
      logic [7:0] rx;
      logic [0:7] seq;   // expected ram_data on writes 0..7, leftmost first
   } vec_t;

   vec_t vecs[5];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{rx: 8'hA5, seq: 8'b1010_0101};
      vecs[1] = '{rx: 8'h3C, seq: 8'b0011_1100};
      vecs[2] = '{rx: 8'h01, seq: 8'b1000_0000};
      vecs[3] = '{rx: 8'h80, seq: 8'b0000_0001};
      vecs[4] = '{rx: 8'h6E, seq: 8'b0111_0110};

      // Reset state
      #3;
      check("rst_busy", busy, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_ram_data", ram_data, 0);
      check("rst_clr_rx_rdy", clr_rx_rdy, 0);
      check("rst_core_start", core_start, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_tx_data", tx_data, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      // core_done while idle must be ignored
      core_digit = 4'd3;
      core_done  = 1'b1;
      @(posedge clk);
      #1 core_done = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("stray_done_busy", busy, 0);
         check("stray_done_tx", tx_start, 0);
      end
      @(posedge clk);
      #1;

      // Table-driven bytes at the start of a frame
      clear_mon();
      for (int k = 0; k < 5; k++) begin
         send_byte(vecs[k].rx);
         for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check("tbl_ram_we", ram_we, 1);
            check("tbl_ram_addr", ram_addr, 8 * k + j);
            check("tbl_ram_data", ram_data, vecs[k].seq[j]);
            check("tbl_clr_one_cycle", clr_rx_rdy, 0);
            check("tbl_busy", busy, 1);
         end
         @(posedge clk);
         #1;
         @(negedge clk);
         check("tbl_idle_busy", busy, 0);
         check("tbl_idle_we", ram_we, 0);
         @(posedge clk);
         #1;
      end

      // Load up to 40 bytes, then reset in the middle of the 41st byte's writes
      for (int k = 5; k < 40; k++) send_byte(8'($urandom));
      send_byte(8'($urandom));
      check("pre_rst_we", ram_we, 1);
      check("pre_rst_addr", ram_addr, 320);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_ram_we", ram_we, 0);
      check("midrst_ram_addr", ram_addr, 0);
      check("midrst_ram_data", ram_data, 0);
      check("midrst_core_start", core_start, 0);
      check("midrst_tx_start", tx_start, 0);
      check("midrst_tx_data", tx_data, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Full frame of 0xFF after the reset
      foreach (frame_bytes[k]) frame_bytes[k] = 8'hFF;
      send_frame(0, 0);

      // WAIT_DONE: core owns the address port, pending rx byte is not taken
      core_addr = 10'h155;
      foreach (frame_bytes[k]) frame_bytes[k] = 8'($urandom);
      rx_data = frame_bytes[0];
      rx_rdy  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("wd_ram_addr", ram_addr, 10'h155);
         check("wd_ram_we", ram_we, 0);
         check("wd_clr_rx_rdy", clr_rx_rdy, 0);
      end
      core_addr = 10'h2A3;
      @(negedge clk);
      check("wd_ram_addr_follow", ram_addr, 10'h2A3);
      @(posedge clk);
      #1;
      check("wd_start_once", start_cnt, 1);
      do_result(4'd7, 0);

      // Pending byte is taken in RX_WAIT and opens a new frame at address 0
      clear_mon();
      wait_ack();
      send_frame(1, 2);

      // Transmit back-pressure
      do_result(4'd9, 20);

      // Randomized frames with random gaps, digits and transmitter busy time
      for (int f = 0; f < 2; f++) begin
         foreach (frame_bytes[k]) frame_bytes[k] = 8'($urandom);
         send_frame(0, 3);
         do_result(4'($urandom_range(9, 0)), $urandom_range(5, 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
